// File: rtl/muldiv_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : muldiv_seq                                                 |
// | Description : Execute-stage sequencer for the multi-cycle multiply and   |
// |               divide units. Resolves trivial divide cases locally, runs  |
// |               the level-held valid/done handshake otherwise, stalls the  |
// |               pipeline while busy and holds the result until accepted.   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module muldiv_seq #(
  parameter int TIMEOUT = 200,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [2:0]       in_op,
  input  logic             in_word,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [63:0]      out_result,
  output logic             stall,
  output logic             mul_valid,
  output logic             div_valid,
  output logic             div_signed,
  output logic [63:0]      u_a,
  output logic [63:0]      u_b,
  input  logic             mul_done,
  input  logic [63:0]      mul_res,
  input  logic             div_done,
  input  logic [63:0]      div_quot,
  input  logic [63:0]      div_rem,
  output logic [CNT_W-1:0] busy_cnt,
  output logic             err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0]       c_OP_MUL  = 3'd0;
  localparam logic [2:0]       c_OP_DIV  = 3'd1;
  localparam logic [2:0]       c_OP_REM  = 3'd2;
  localparam logic [2:0]       c_OP_DIVU = 3'd3;
  localparam logic [2:0]       c_OP_REMU = 3'd4;
  localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);

  state_t            r_state;
  logic              r_word;
  logic              r_is_rem;
  logic              r_unit_div;
  logic              r_out_valid;
  logic              r_mul_valid;
  logic              r_div_valid;
  logic              r_div_signed;
  logic              r_err;
  logic [63:0]       r_ua;
  logic [63:0]       r_ub;
  logic [63:0]       r_res;
  logic [CNT_W-1:0]  r_busy_cnt;

  logic              w_sext_op;
  logic              w_is_div;
  logic              w_is_rem;
  logic              w_sdiv;
  logic              w_illegal;
  logic [63:0]       w_a;
  logic [63:0]       w_b;
  logic [63:0]       w_min;
  logic              w_b_zero;
  logic              w_ovf;
  logic              w_fast;
  logic [63:0]       w_fast_res;
  logic              w_sel_done;
  logic [63:0]       w_sel_res;
  logic              w_timeout;

  // W results are the low word sign-extended; applied once at capture time
  function automatic logic [63:0] f_word_adj(input logic [63:0] v, input logic w);
    f_word_adj = w ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  // Decode the incoming op and prepare operands / fast-path result
  always_comb begin
    w_sext_op  = (in_op == c_OP_MUL) | (in_op == c_OP_DIV) | (in_op == c_OP_REM);
    w_is_div   = (in_op == c_OP_DIV) | (in_op == c_OP_REM) |
                 (in_op == c_OP_DIVU) | (in_op == c_OP_REMU);
    w_is_rem   = (in_op == c_OP_REM) | (in_op == c_OP_REMU);
    w_sdiv     = (in_op == c_OP_DIV) | (in_op == c_OP_REM);
    w_illegal  = (in_op > c_OP_REMU);
    w_a        = in_a;
    w_b        = in_b;
    if (in_word) begin
      w_a = w_sext_op ? {{32{in_a[31]}}, in_a[31:0]} : {32'd0, in_a[31:0]};
      w_b = w_sext_op ? {{32{in_b[31]}}, in_b[31:0]} : {32'd0, in_b[31:0]};
    end
    w_min      = in_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    w_b_zero   = (w_b == 64'd0);
    w_ovf      = w_sdiv & (w_a == w_min) & (w_b == {64{1'b1}});
    w_fast     = w_illegal | (w_is_div & (w_b_zero | w_ovf));
    w_fast_res = 64'd0;
    if (w_illegal) begin
      w_fast_res = 64'd0;
    end else if (w_b_zero) begin
      w_fast_res = w_is_rem ? w_a : {64{1'b1}};
    end else if (w_ovf) begin
      w_fast_res = w_is_rem ? 64'd0 : w_min;
    end
  end

  // Only the unit selected at accept time may complete the op
  assign w_sel_done = r_unit_div ? div_done : mul_done;
  assign w_sel_res  = r_unit_div ? (r_is_rem ? div_rem : div_quot) : mul_res;
  assign w_timeout  = (r_busy_cnt == c_TIMEOUT);

  // Pipeline freeze request; a flush always releases the pipeline
  assign stall = ~flush & (((r_state == S_IDLE) & in_valid) |
                           (r_state == S_BUSY) |
                           ((r_state == S_DONE) & ~out_ready));

  assign out_valid  = r_out_valid;
  assign out_result = r_res;
  assign mul_valid  = r_mul_valid;
  assign div_valid  = r_div_valid;
  assign div_signed = r_div_signed;
  assign u_a        = r_ua;
  assign u_b        = r_ub;
  assign busy_cnt   = r_busy_cnt;
  assign err_o      = r_err;

  // Sequencer state machine with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_word       <= 1'b0;
      r_is_rem     <= 1'b0;
      r_unit_div   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_mul_valid  <= 1'b0;
      r_div_valid  <= 1'b0;
      r_div_signed <= 1'b0;
      r_err        <= 1'b0;
      r_ua         <= 64'd0;
      r_ub         <= 64'd0;
      r_res        <= 64'd0;
      r_busy_cnt   <= '0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_mul_valid <= 1'b0;
      r_div_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_ua         <= w_a;
            r_ub         <= w_b;
            r_word       <= in_word;
            r_is_rem     <= w_is_rem;
            r_unit_div   <= w_is_div;
            r_div_signed <= w_sdiv;
            if (w_fast) begin
              r_res       <= f_word_adj(w_fast_res, in_word);
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_busy_cnt  <= '0;
              r_mul_valid <= ~w_is_div;
              r_div_valid <= w_is_div;
              r_state     <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (w_sel_done) begin
            r_res       <= f_word_adj(w_sel_res, r_word);
            r_mul_valid <= 1'b0;
            r_div_valid <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_timeout) begin
            r_err       <= 1'b1;
            r_res       <= 64'd0;
            r_mul_valid <= 1'b0;
            r_div_valid <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_busy_cnt  <= r_busy_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_mul_valid <= 1'b0;
          r_div_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
